// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: registered single-cycle ops plus an iterative shift-add MULTPLUS.
// Optional macro ALU_EARLY_TERM_EN stops the multiplier once the shifted multiplier is zero.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALUOperation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Addend,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             busy,
    output logic             done
);

    localparam int              CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   COUNT_MAX = CW'(WIDTH);
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

    state_t           r_state;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_opA;
    logic [WIDTH-1:0] r_opB;
    logic [WIDTH-1:0] r_addend;
    logic [WIDTH-1:0] r_acc;
    logic [CW-1:0]    r_count;

    logic [WIDTH-1:0] w_execResult;
    logic [WIDTH-1:0] w_accNext;
    logic [WIDTH-1:0] w_mulResult;
    logic             w_mulFinish;

    // r_opA/r_opB double as multiplicand/multiplier while in MUL.
    always_comb begin
        w_execResult = '0;
        case (r_op)
            4'b0000: w_execResult = r_opA & r_opB;
            4'b0001: w_execResult = r_opA | r_opB;
            4'b0010: w_execResult = ~(r_opA | r_opB);
            4'b0011: w_execResult = r_opA + r_opB;
            4'b0100: w_execResult = r_opA - r_opB;
            4'b1111: w_execResult = r_opA + ONE;
            default: w_execResult = '0;
        endcase
    end

    assign w_accNext   = r_opB[0] ? (r_acc + r_opA) : r_acc;
    assign w_mulResult = r_acc + r_addend;

`ifdef ALU_EARLY_TERM_EN
    // At least one iteration always runs, so B=0 still costs one cycle.
    assign w_mulFinish = (r_count == COUNT_MAX) || ((r_count != '0) && (r_opB == '0));
`else
    assign w_mulFinish = (r_count == COUNT_MAX);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_op      <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_addend  <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            ALUResult <= '0;
            Zero      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_op     <= ALUOperation;
                        r_opA    <= A;
                        r_opB    <= B;
                        r_addend <= Addend;
                        r_acc    <= '0;
                        r_count  <= '0;
                        busy     <= 1'b1;
                        r_state  <= (ALUOperation == 4'b1010) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    ALUResult <= w_execResult;
                    Zero      <= (w_execResult == '0);
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    r_state   <= DONE;
                end
                MUL: begin
                    if (w_mulFinish) begin
                        ALUResult <= w_mulResult;
                        Zero      <= (w_mulResult == '0);
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_acc   <= w_accNext;
                        r_opA   <= r_opA << 1;
                        r_opB   <= r_opB >> 1;
                        r_count <= r_count + 1'b1;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: a transaction-level reference model checked
// every cycle, plus directed vectors with hand-computed results and latencies.
module tb_alu_multicycle;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       ALUOperation = 4'b0000;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [WIDTH-1:0] Addend = '0;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             busy;
    logic             done;

    int testsRun = 0;
    int testsFailed = 0;

    alu_multicycle #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ALUOperation(ALUOperation),
        .A(A),
        .B(B),
        .Addend(Addend),
        .ALUResult(ALUResult),
        .Zero(Zero),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Arithmetic result of one operation, straight from the opcode table.
    function automatic logic [WIDTH-1:0] refResult(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] add);
        logic [2*WIDTH-1:0] full;
        full = '0;
        case (op)
            4'b0000: full = {{WIDTH{1'b0}}, a & b};
            4'b0001: full = {{WIDTH{1'b0}}, a | b};
            4'b0010: full = {{WIDTH{1'b0}}, ~(a | b)};
            4'b0011: full = {{WIDTH{1'b0}}, a} + {{WIDTH{1'b0}}, b};
            4'b0100: full = {{WIDTH{1'b0}}, a - b};
            4'b1111: full = {{WIDTH{1'b0}}, a} + 1;
            4'b1010: full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b} + {{WIDTH{1'b0}}, add};
            default: full = '0;
        endcase
        return full[WIDTH-1:0];
    endfunction

    // Clocks from the start edge (counted as clock 1) to done high.
    function automatic int refLatency(input logic [3:0] op, input logic [WIDTH-1:0] b);
        int hb;
        hb = 0;
        if (op != 4'b1010) return 2;
`ifdef ALU_EARLY_TERM_EN
        for (int i = 0; i < WIDTH; i++) if (b[i]) hb = i;
        return (b == '0) ? 3 : hb + 3;
`else
        hb = int'(b[0]);
        return WIDTH + 2 + hb - hb;
`endif
    endfunction

    // Reference model: one transaction at a time, counted down in clocks.
    logic [WIDTH-1:0] mResult = '0;
    logic [WIDTH-1:0] mPending = '0;
    logic             mZero = 1'b1;
    logic             mBusy = 1'b0;
    logic             mDone = 1'b0;
    int               mRemain = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mResult = '0;
            mZero   = 1'b1;
            mBusy   = 1'b0;
            mDone   = 1'b0;
            mRemain = 0;
        end else if (mDone) begin
            mDone = 1'b0;
        end else if (mBusy) begin
            mRemain--;
            if (mRemain == 0) begin
                mResult = mPending;
                mZero   = (mPending == '0);
                mDone   = 1'b1;
                mBusy   = 1'b0;
            end
        end else if (start) begin
            mPending = refResult(ALUOperation, A, B, Addend);
            mRemain  = refLatency(ALUOperation, B) - 1;
            mBusy    = 1'b1;
        end
    end

    // Every cycle the DUT outputs must match the model.
    always @(negedge clk) begin
        checkOutput("cycle ALUResult", ALUResult, mResult);
        checkOutput("cycle Zero", WIDTH'(Zero), WIDTH'(mZero));
        checkOutput("cycle busy", WIDTH'(busy), WIDTH'(mBusy));
        checkOutput("cycle done", WIDTH'(done), WIDTH'(mDone));
    end

    // Issue one operation, scramble inputs after capture, wait (bounded) for done.
    task automatic applyStimulus(input string name, input logic [3:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] add,
                                 input logic [WIDTH-1:0] expResult, input logic expZero,
                                 input int expLatency, input bit pulseWhileBusy);
        int lat;
        @(negedge clk);
        ALUOperation = op;
        A = a;
        B = b;
        Addend = add;
        start = 1'b1;
        @(negedge clk);
        lat = 1;
        checkOutput({name, " busy@1"}, WIDTH'(busy), WIDTH'(1'b1));
        start = pulseWhileBusy;
        A = $urandom;
        B = $urandom;
        Addend = $urandom;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
            if (pulseWhileBusy && lat < 12) begin
                A = $urandom;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        checkOutput({name, " latency"}, WIDTH'(lat), WIDTH'(expLatency));
        checkOutput({name, " result"}, ALUResult, expResult);
        checkOutput({name, " Zero"}, WIDTH'(Zero), WIDTH'(expZero));
    endtask

    localparam int MUL_LAT_3000 =
`ifdef ALU_EARLY_TERM_EN
        14;
`else
        34;
`endif
    localparam int MUL_LAT_10000 =
`ifdef ALU_EARLY_TERM_EN
        19;
`else
        34;
`endif

    initial begin
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset ALUResult", ALUResult, '0);
        checkOutput("reset Zero", WIDTH'(Zero), WIDTH'(1'b1));
        checkOutput("reset busy", WIDTH'(busy), WIDTH'(1'b0));
        checkOutput("reset done", WIDTH'(done), WIDTH'(1'b0));
        reset = 1'b0;

        applyStimulus("AND", 4'b0000, 32'h0000F0F0, 32'h00FF00FF, 32'h0, 32'h000000F0, 1'b0, 2, 1'b0);
        applyStimulus("OR",  4'b0001, 32'h0000F0F0, 32'h00FF00FF, 32'h0, 32'h00FFF0FF, 1'b0, 2, 1'b0);
        applyStimulus("NOR", 4'b0010, 32'h0000F0F0, 32'h00FF00FF, 32'h0, 32'hFF000F00, 1'b0, 2, 1'b0);
        applyStimulus("ADD", 4'b0011, 32'h0000F0F0, 32'h00FF00FF, 32'h0, 32'h00FFF1EF, 1'b0, 2, 1'b0);
        applyStimulus("SUB", 4'b0100, 32'h12345678, 32'h12345678, 32'h0, 32'h0, 1'b1, 2, 1'b0);
        applyStimulus("INC", 4'b1111, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 1'b1, 2, 1'b0);
        applyStimulus("MULTPLUS", 4'b1010, 32'd1000, 32'd3000, 32'd7, 32'd3000007, 1'b0, MUL_LAT_3000, 1'b0);
        applyStimulus("MUL ovf", 4'b1010, 32'h00010000, 32'h00010000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0,
                      MUL_LAT_10000, 1'b0);
        applyStimulus("UNKNOWN", 4'b0111, 32'h0000F0F0, 32'h00FF00FF, 32'h0, 32'h0, 1'b1, 2, 1'b0);
        applyStimulus("MUL busy start", 4'b1010, 32'd1000, 32'd3000, 32'd7, 32'd3000007, 1'b0,
                      MUL_LAT_3000, 1'b1);

        // Abort a multiply mid-flight; outputs must drop to reset values at once.
        @(negedge clk);
        ALUOperation = 4'b1010;
        A = 32'd5;
        B = 32'd7;
        Addend = 32'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("midreset ALUResult", ALUResult, '0);
        checkOutput("midreset Zero", WIDTH'(Zero), WIDTH'(1'b1));
        checkOutput("midreset busy", WIDTH'(busy), WIDTH'(1'b0));
        checkOutput("midreset done", WIDTH'(done), WIDTH'(1'b0));
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("post-reset done", WIDTH'(done), WIDTH'(1'b0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
